disp_channel_mux: RTL and testbench
===================================

# disp_channel_mux

Parametrised debug-display controller for the board-level computer top. It selects one of CHANNELS internal data buses (PC, RegA, RegB, ALU, …) with a debounced push button, and drives the 4 LEDs with the selected value's low nibble. It converts the selected value to two decimal digits with a sequential double-dabble engine and drives both 7-segment digits. It generalises the fixed 4-mode, 4-bit display path to arbitrary channel count and data width, adds an overflow indication, and optionally adds automatic channel scanning.

## Interface
- CHANNELS, 4, number of selectable input channels (2..16)
- WIDTH, 8, bits per channel (4..16)
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a button level change
- SCAN_PERIOD, 25000000, cycles between automatic advances (only used with AUTO_SCAN_EN)
- CLK  in  1  system clock, single clock domain
- RESET  in  1  synchronous, active-high reset
- i_btn_n  in  1  raw select button, active low, asynchronous to CLK
- i_auto  in  1  level; enables automatic scanning (AUTO_SCAN_EN only)
- i_ch_data  in  CHANNELS*WIDTH  packed channel buses; channel k at [k*WIDTH +: WIDTH]
- o_sel  out  clog2(CHANNELS)  currently selected channel
- o_leds  out  4  selected value [3:0], active high; o_leds[3] drives LED1
- o_seg_tens  out  7  tens digit {a,b,c,d,e,f,g}, active low
- o_seg_ones  out  7  ones digit {a,b,c,d,e,f,g}, active low
- o_ovf  out  1  selected value > 99

## Operation
- Button path: 2-flop synchroniser, then debouncer. The stable level changes only after the synchronised input has differed from it for DEBOUNCE_LIMIT consecutive cycles; any agreement clears the counter. A stable 1→0 transition produces a one-cycle press pulse. Releases produce no pulse.
- Selection: a press increments o_sel, wrapping from CHANNELS-1 to 0.
- LEDs: register the selected channel's [3:0] every cycle.
- Converter FSM has three states:
  - IDLE: waits for a start condition.
  - SHIFT: runs WIDTH iterations of add-3/shift into a 5-digit BCD register.
  - DONE: latches the result into the display registers, then returns to IDLE.
- Start condition: IDLE and (the selected value differs from the last converted snapshot, or o_sel changed). On start, the value is captured into the snapshot.
- If the input changes during SHIFT, the current conversion completes and its result is displayed. The next conversion then starts from IDLE with the latest value.
- Display: if the BCD hundreds, thousands or ten-thousands digit is nonzero, o_ovf=1 and both digits show "-" (1111110). Otherwise o_ovf=0 and the digits show tens/ones. There is no leading-zero blanking.
- Segment codes 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.

## Timing
- Reset values:
  - o_sel=0, o_leds=0000, o_seg_tens=o_seg_ones=0000001 ("00"), o_ovf=0.
  - Debounce stable level=1, debounce and scan counters=0, FSM=IDLE, snapshot=0.
- RESET asserted mid-conversion aborts it; no stale result appears after release.
- Press latency: o_sel changes 2 (sync) + DEBOUNCE_LIMIT + 1 cycles after i_btn_n falls and stays low.
- o_leds lags a channel-data or o_sel change by 1 cycle.
- Digits/o_ovf update WIDTH+2 cycles after a change seen in IDLE: capture, WIDTH shift cycles, DONE.
- Glitches shorter than DEBOUNCE_LIMIT cycles are ignored.

## Configuration
- AUTO_SCAN_EN defined:
  - While i_auto=1, a counter advances o_sel every SCAN_PERIOD cycles.
  - Any advance (press or tick) restarts the counter.
  - A press and a tick in the same cycle advance o_sel by exactly one.
  - i_auto=0 holds the counter at 0.
- AUTO_SCAN_EN undefined: no scan counter is built, i_auto is ignored, and o_sel changes only on presses.

## Test plan
All scenarios use CHANNELS=4, WIDTH=8 and DEBOUNCE_LIMIT=5 unless noted.
- RESET high 3 cycles → o_sel=0, o_leds=0000, both segments 0000001, o_ovf=0.
- ch0=0x2A → after 10 cycles tens=1001100 ("4"), ones=0010010 ("2"), o_leds=1010, o_ovf=0.
- i_btn_n low 3 cycles → o_sel unchanged. Low 20 cycles → o_sel=1 exactly once. Four full press/release pairs from 0 → o_sel wraps back to 0.
- Selected value 0xC8 (200) → o_ovf=1, both digits 1111110. Change to 0x63 during SHIFT → 200 result shown first, then "99" within 10 further cycles.
- AUTO_SCAN_EN, SCAN_PERIOD=8, i_auto=1 → o_sel advances every 8 cycles. Press aligned with a tick → single increment. Macro undefined → o_sel constant.
- RESET asserted during SHIFT with ch0=99 → outputs return to reset values. After release the conversion restarts and "99" appears 10 cycles later.

Source files
------------

// File: rtl/disp_channel_mux.sv
// Debug display: debounced channel select, LED nibble, sequential double-dabble to two 7-segment digits.
// Optional automatic channel scanning is built when AUTO_SCAN_EN is defined.
module disp_channel_mux #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SCAN_PERIOD    = 25000000
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          i_btn_n,
  input  logic                          i_auto,
  input  logic [CHANNELS*WIDTH-1:0]     i_ch_data,
  output logic [$clog2(CHANNELS)-1:0]   o_sel,
  output logic [3:0]                    o_leds,
  output logic [6:0]                    o_seg_tens,
  output logic [6:0]                    o_seg_ones,
  output logic                          o_ovf
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int DB_W  = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int IT_W  = $clog2(WIDTH + 1);
  localparam int BCD_W = 20;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_ZERO = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int d = 0; d < BCD_W / 4; d++)
      if (r[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic             stable_q, stable_d, press_q, press_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d, snap_sel_q, snap_sel_d;
  logic [3:0]       leds_q, leds_d;
  logic [6:0]       tens_q, tens_d, ones_q, ones_d;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;
  logic [IT_W-1:0]  it_q, it_d;
  logic [WIDTH-1:0] snap_q, snap_d, bin_q, bin_d, cur_val;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic             advance;

`ifdef AUTO_SCAN_EN
  localparam int SCAN_W = $clog2(SCAN_PERIOD + 1);
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic              tick;
`else
  logic unused_auto;
  assign unused_auto = i_auto;
`endif

  always_comb begin
    cur_val = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (sel_q == SEL_W'(k)) cur_val = i_ch_data[k*WIDTH +: WIDTH];
  end

  always_comb begin
    btn_s1_d   = i_btn_n;
    btn_s2_d   = btn_s1_q;
    stable_d   = stable_q;
    db_cnt_d   = '0;
    sel_d      = sel_q;
    snap_d     = snap_q;
    snap_sel_d = snap_sel_q;
    leds_d     = cur_val[3:0];
    tens_d     = tens_q;
    ones_d     = ones_q;
    ovf_d      = ovf_q;
    state_d    = state_q;
    it_d       = it_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    shifted    = {add3(bcd_q), bin_q} << 1;

    // Any sample agreeing with the stable level clears the run counter.
    if (btn_s2_q != stable_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_LIMIT - 1)) stable_d = btn_s2_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
    press_d = stable_q & ~stable_d;
    advance = press_q;
`ifdef AUTO_SCAN_EN
    tick       = i_auto && (scan_cnt_q == SCAN_W'(SCAN_PERIOD - 1));
    advance    = press_q | tick;
    scan_cnt_d = (!i_auto || advance) ? '0 : scan_cnt_q + 1'b1;
`endif
    if (advance) sel_d = (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cur_val != snap_q || sel_q != snap_sel_q) begin
          snap_d     = cur_val;
          snap_sel_d = sel_q;
          bin_d      = cur_val;
          bcd_d      = '0;
          it_d       = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = shifted[BCD_W+WIDTH-1:WIDTH];
        bin_d = shifted[WIDTH-1:0];
        it_d  = it_q + 1'b1;
        if (it_q == IT_W'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        ovf_d   = |bcd_q[BCD_W-1:8];
        tens_d  = ovf_d ? SEG_DASH : seg7(bcd_q[7:4]);
        ones_d  = ovf_d ? SEG_DASH : seg7(bcd_q[3:0]);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_s1_q   <= 1'b1;
      btn_s2_q   <= 1'b1;
      stable_q   <= 1'b1;
      press_q    <= 1'b0;
      db_cnt_q   <= '0;
      sel_q      <= '0;
      snap_sel_q <= '0;
      snap_q     <= '0;
      leds_q     <= '0;
      tens_q     <= SEG_ZERO;
      ones_q     <= SEG_ZERO;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      it_q       <= '0;
`ifdef AUTO_SCAN_EN
      scan_cnt_q <= '0;
`endif
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      stable_q   <= stable_d;
      press_q    <= press_d;
      db_cnt_q   <= db_cnt_d;
      sel_q      <= sel_d;
      snap_sel_q <= snap_sel_d;
      snap_q     <= snap_d;
      leds_q     <= leds_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      it_q       <= it_d;
`ifdef AUTO_SCAN_EN
      scan_cnt_q <= scan_cnt_d;
`endif
    end
  end

  // Conversion datapath: only read after a capture, so it needs no reset.
  always_ff @(posedge CLK) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  assign o_sel      = sel_q;
  assign o_leds     = leds_q;
  assign o_seg_tens = tens_q;
  assign o_seg_ones = ones_q;
  assign o_ovf      = ovf_q;
endmodule

// File: tb/tb_disp_channel_mux.sv
// Directed bench for disp_channel_mux (CHANNELS=4, WIDTH=8, DEBOUNCE_LIMIT=5, SCAN_PERIOD=8).
module tb_disp_channel_mux;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam logic [6:0] SEG0 = 7'b0000001;
  localparam logic [6:0] SEG1 = 7'b1001111;
  localparam logic [6:0] SEG2 = 7'b0010010;
  localparam logic [6:0] SEG4 = 7'b1001100;
  localparam logic [6:0] SEG9 = 7'b0000100;
  localparam logic [6:0] DASH = 7'b1111110;

  logic          clk = 1'b0;
  logic          rst, btn_n, auto_en;
  logic [CH*W-1:0] ch_data;
  logic [1:0]    sel;
  logic [3:0]    leds;
  logic [6:0]    seg_tens, seg_ones;
  logic          ovf;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  disp_channel_mux #(
    .CHANNELS(CH), .WIDTH(W), .DEBOUNCE_LIMIT(5), .SCAN_PERIOD(8)
  ) dut (
    .CLK(clk), .RESET(rst), .i_btn_n(btn_n), .i_auto(auto_en),
    .i_ch_data(ch_data), .o_sel(sel), .o_leds(leds),
    .o_seg_tens(seg_tens), .o_seg_ones(seg_ones), .o_ovf(ovf)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic press_release();
    btn_n = 1'b0;
    step(10);
    btn_n = 1'b1;
    step(10);
  endtask

  initial begin
    rst = 1'b1; btn_n = 1'b1; auto_en = 1'b0; ch_data = '0;
    step(3);
    check("rst_sel",  16'(sel), 16'd0);
    check("rst_leds", 16'(leds), 16'd0);
    check("rst_tens", 16'(seg_tens), 16'(SEG0));
    check("rst_ones", 16'(seg_ones), 16'(SEG0));
    check("rst_ovf",  16'(ovf), 16'd0);

    // ch0=42, ch1=21, ch2=91, ch3=15
    rst = 1'b0;
    ch_data = {8'h0F, 8'h5B, 8'h15, 8'h2A};
    step(9);
    check("conv_not_yet", 16'(seg_ones), 16'(SEG0));
    step(1);
    check("conv42_tens", 16'(seg_tens), 16'(SEG4));
    check("conv42_ones", 16'(seg_ones), 16'(SEG2));
    check("conv42_leds", 16'(leds), 16'hA);
    check("conv42_ovf",  16'(ovf), 16'd0);

    btn_n = 1'b0; step(3); btn_n = 1'b1; step(20);
    check("glitch_sel", 16'(sel), 16'd0);

    btn_n = 1'b0;
    step(7);
    check("press_lat_before", 16'(sel), 16'd0);
    step(1);
    check("press_lat_at", 16'(sel), 16'd1);
    step(12);
    check("press_once", 16'(sel), 16'd1);
    check("ch1_leds", 16'(leds), 16'h5);
    check("ch1_tens", 16'(seg_tens), 16'(SEG2));
    check("ch1_ones", 16'(seg_ones), 16'(SEG1));
    btn_n = 1'b1;
    step(10);
    check("release_no_pulse", 16'(sel), 16'd1);

    press_release();
    check("wrap_sel2", 16'(sel), 16'd2);
    press_release();
    check("wrap_sel3", 16'(sel), 16'd3);
    press_release();
    check("wrap_sel0", 16'(sel), 16'd0);
    check("back_ch0_tens", 16'(seg_tens), 16'(SEG4));
    check("back_ch0_ones", 16'(seg_ones), 16'(SEG2));

    ch_data[7:0] = 8'hC8;
    step(3);
    ch_data[7:0] = 8'h63;
    step(7);
    check("ovf_flag", 16'(ovf), 16'd1);
    check("ovf_tens", 16'(seg_tens), 16'(DASH));
    check("ovf_ones", 16'(seg_ones), 16'(DASH));
    step(9);
    check("ovf_held", 16'(ovf), 16'd1);
    step(1);
    check("redo_ovf",  16'(ovf), 16'd0);
    check("redo_tens", 16'(seg_tens), 16'(SEG9));
    check("redo_ones", 16'(seg_ones), 16'(SEG9));
    check("redo_leds", 16'(leds), 16'h3);

`ifdef AUTO_SCAN_EN
    auto_en = 1'b1;
    step(7);
    check("scan_before", 16'(sel), 16'd0);
    step(1);
    check("scan_tick1", 16'(sel), 16'd1);
    step(8);
    check("scan_tick2", 16'(sel), 16'd2);
    btn_n = 1'b0;
    step(8);
    check("scan_press_tick", 16'(sel), 16'd3);
    step(8);
    check("scan_tick_wrap", 16'(sel), 16'd0);
    auto_en = 1'b0;
    btn_n = 1'b1;
    step(20);
    check("scan_off_hold", 16'(sel), 16'd0);
`else
    auto_en = 1'b1;
    step(20);
    check("no_scan_sel", 16'(sel), 16'd0);
    auto_en = 1'b0;
`endif

    ch_data[7:0] = 8'hC8;
    step(12);
    check("pre_rst_ovf", 16'(ovf), 16'd1);
    ch_data[7:0] = 8'h63;
    step(4);
    rst = 1'b1;
    step(2);
    check("mid_rst_sel",  16'(sel), 16'd0);
    check("mid_rst_leds", 16'(leds), 16'd0);
    check("mid_rst_tens", 16'(seg_tens), 16'(SEG0));
    check("mid_rst_ones", 16'(seg_ones), 16'(SEG0));
    check("mid_rst_ovf",  16'(ovf), 16'd0);
    rst = 1'b0;
    step(9);
    check("post_rst_no_stale", 16'(seg_ones), 16'(SEG0));
    step(1);
    check("post_rst_tens", 16'(seg_tens), 16'(SEG9));
    check("post_rst_ones", 16'(seg_ones), 16'(SEG9));
    check("post_rst_ovf",  16'(ovf), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
